ddr_note_scheduler: RTL and testbench

- Sequences DDR gameplay while the game state is GAME.
- Generates the beat timebase and spawns arrows from an LFSR pattern into a scrolling lane field.
- Judges player lane presses against the arrow row that reaches the hit line.
- Maintains combo, max combo and score for the display path. Sits between the state generator and the display/scoring logic.

---
 rtl/ddr_note_scheduler_if.sv | 27 ++
 rtl/ddr_note_scheduler.sv | 144 ++++++++++++++
 tb/tb_ddr_note_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ddr_note_scheduler_if.sv
// Bus between the state generator / button front end and the DDR note scheduler.
// The scheduler takes the slave side; whoever drives game_state and btn_lane takes the master side.
interface ddr_note_scheduler_if #(
    parameter int ROWS    = 8,
    parameter int COMBO_W = 8,
    parameter int SCORE_W = 16
);
    logic [1:0]          game_state;
    logic [3:0]          btn_lane;
    logic [4*ROWS-1:0]   field;
    logic                beat_pulse;
    logic                hit_pulse;
    logic                miss_pulse;
    logic [COMBO_W-1:0]  combo;
    logic [COMBO_W-1:0]  max_combo;
    logic [SCORE_W-1:0]  score;

    modport master (
        output game_state, btn_lane,
        input  field, beat_pulse, hit_pulse, miss_pulse, combo, max_combo, score
    );

    modport slave (
        input  game_state, btn_lane,
        output field, beat_pulse, hit_pulse, miss_pulse, combo, max_combo, score
    );
endinterface

// File: rtl/ddr_note_scheduler.sv
// DDR gameplay sequencer: beat timebase, LFSR arrow spawning, scrolling lane field,
// hit-line judgement and combo/score bookkeeping.
module ddr_note_scheduler #(
    parameter int         TICK_DIV    = 25000000,
    parameter int         ROWS        = 8,
    parameter int         SPAWN_EVERY = 2,
    parameter logic [7:0] SEED        = 8'hA5,
    parameter int         POINTS      = 10,
    parameter int         COMBO_W     = 8,
    parameter int         SCORE_W     = 16,
    parameter logic [1:0] STATE_RESET = 2'd0,
    parameter logic [1:0] STATE_PAUSE = 2'd1,
    parameter logic [1:0] STATE_GAME  = 2'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr_note_scheduler_if.slave   bus
);
    localparam int TC_W  = $clog2(TICK_DIV);
    localparam int SC_W  = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;
    localparam int CS_W  = COMBO_W + 3;
    localparam int SS_W  = SCORE_W + 32;
    localparam int FW    = 4 * ROWS;

    logic [TC_W-1:0]    tc_q;
    logic [SC_W-1:0]    sc_q;
    logic [7:0]         lfsr_q;
    logic [3:0]         pressed_q;
    logic [FW-1:0]      field_q;
    logic [COMBO_W-1:0] combo_q;
    logic [COMBO_W-1:0] max_q;
    logic [SCORE_W-1:0] score_q;
    logic               beat_q;
    logic               hit_q;
    logic               miss_q;

    logic               is_game;
    logic               beat;
    logic [3:0]         top_row;
    logic [3:0]         press_all;
    logic [3:0]         hits;
    logic               any_miss;
    logic               any_hit;
    logic [2:0]         hit_cnt;
    logic [CS_W-1:0]    combo_sum;
    logic [SS_W-1:0]    score_sum;
    logic [COMBO_W-1:0] combo_next;
    logic [COMBO_W-1:0] max_next;
    logic [SCORE_W-1:0] score_next;
    logic [3:0]         spawn_vec;
    logic [7:0]         lfsr_next;
    logic [SC_W-1:0]    sc_next;
    logic [FW-1:0]      field_next;

    // Judgement, saturation and scroll values that are committed on the beat edge.
    always_comb begin
        is_game    = (bus.game_state == STATE_GAME);
        beat       = is_game && (tc_q == TC_W'(TICK_DIV - 1));
        top_row    = field_q[FW-1 -: 4];
        press_all  = pressed_q | bus.btn_lane;
        hits       = top_row & press_all;
        any_miss   = ((top_row & ~press_all) | (~top_row & press_all)) != 4'b0000;
        any_hit    = (hits != 4'b0000);
        hit_cnt    = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        combo_sum  = CS_W'(combo_q) + CS_W'(hit_cnt);
        score_sum  = SS_W'(score_q) + SS_W'(hit_cnt) * SS_W'(POINTS);

        combo_next = combo_q;
        score_next = score_q;
        if (any_miss) begin
            combo_next = '0;
        end else if (any_hit) begin
            combo_next = (combo_sum > CS_W'({COMBO_W{1'b1}})) ? {COMBO_W{1'b1}}
                                                               : combo_sum[COMBO_W-1:0];
            score_next = (score_sum > SS_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                               : score_sum[SCORE_W-1:0];
        end
        max_next   = (combo_next > max_q) ? combo_next : max_q;

        spawn_vec  = (sc_q == '0) ? (4'b0001 << lfsr_q[1:0]) : 4'b0000;
        lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        sc_next    = (sc_q == SC_W'(SPAWN_EVERY - 1)) ? '0 : sc_q + SC_W'(1);
        field_next = {field_q[FW-5:0], spawn_vec};
    end

    // STATE_RESET behaves like the async reset but synchronously; pause holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q      <= '0;
            sc_q      <= '0;
            lfsr_q    <= SEED;
            pressed_q <= 4'b0000;
            field_q   <= '0;
            combo_q   <= '0;
            max_q     <= '0;
            score_q   <= '0;
            beat_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else if (bus.game_state == STATE_RESET) begin
            tc_q      <= '0;
            sc_q      <= '0;
            lfsr_q    <= SEED;
            pressed_q <= 4'b0000;
            field_q   <= '0;
            combo_q   <= '0;
            max_q     <= '0;
            score_q   <= '0;
            beat_q    <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else if (is_game) begin
            beat_q <= beat;
            hit_q  <= beat && !any_miss && any_hit;
            miss_q <= beat && any_miss;
            if (beat) begin
                tc_q      <= '0;
                pressed_q <= 4'b0000;
                field_q   <= field_next;
                combo_q   <= combo_next;
                max_q     <= max_next;
                score_q   <= score_next;
                sc_q      <= sc_next;
                lfsr_q    <= lfsr_next;
            end else begin
                tc_q      <= tc_q + TC_W'(1);
                pressed_q <= press_all;
            end
        end else begin
            beat_q <= 1'b0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end
    end

    assign bus.field      = field_q;
    assign bus.beat_pulse = beat_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_ddr_note_scheduler.sv
// Directed bench for ddr_note_scheduler with TICK_DIV=4, ROWS=4, SPAWN_EVERY=2, SEED=8'h01, COMBO_W=2.
// Arrow lanes come from the hand-stepped LFSR sequence 01,02,04,08,11,23,47,8E,1C,38,71,E2,C4,89,12.
module tb_ddr_note_scheduler;
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_GAME  = 2'd2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ddr_note_scheduler_if #(.ROWS(4), .COMBO_W(2), .SCORE_W(16)) bus ();

    ddr_note_scheduler #(
        .TICK_DIV(4), .ROWS(4), .SPAWN_EVERY(2), .SEED(8'h01), .POINTS(10),
        .COMBO_W(2), .SCORE_W(16),
        .STATE_RESET(ST_RESET), .STATE_PAUSE(ST_PAUSE), .STATE_GAME(ST_GAME)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full beat interval from tc=0: press0 lands on a non-beat cycle, press3 on the beat cycle.
    task automatic applyStimulus(input string tag, input logic [3:0] press0, input logic [3:0] press3);
        int early;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_lane = (i == 0) ? press0 : ((i == 3) ? press3 : 4'b0000);
            tick();
            if (i == 0)
                checkOutput({tag, "_pulse_clear"},
                            {29'b0, bus.beat_pulse, bus.hit_pulse, bus.miss_pulse}, 32'd0);
            if (i < 3 && bus.beat_pulse) early++;
        end
        bus.btn_lane = 4'b0000;
        checkOutput({tag, "_early_beat"}, early, 32'd0);
        checkOutput({tag, "_beat"}, {31'b0, bus.beat_pulse}, 32'd1);
    endtask

    task automatic checkJudge(input string tag, input logic hit, input logic miss,
                              input int combo, input int max_combo, input int score);
        checkOutput({tag, "_hit"},   {31'b0, bus.hit_pulse},  {31'b0, hit});
        checkOutput({tag, "_miss"},  {31'b0, bus.miss_pulse}, {31'b0, miss});
        checkOutput({tag, "_combo"}, {30'b0, bus.combo},      combo);
        checkOutput({tag, "_max"},   {30'b0, bus.max_combo},  max_combo);
        checkOutput({tag, "_score"}, {16'b0, bus.score},      score);
    endtask

    initial begin
        int pause_pulses;
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.game_state = ST_RESET;
        bus.btn_lane   = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_field", {16'b0, bus.field}, 32'h0);
        checkJudge("rst", 1'b0, 1'b0, 0, 0, 0);
        checkOutput("rst_beat", {31'b0, bus.beat_pulse}, 32'd0);

        // Spawns on odd beats: b1 lane1, b3 lane0, b5 lane1, b7 lane3, b9 lane0, b11 lane1, b13 lane0.
        bus.game_state = ST_GAME;
        applyStimulus("b1", 4'b0000, 4'b0000);
        checkOutput("b1_field", {16'b0, bus.field}, 32'h0002);
        applyStimulus("b2", 4'b0000, 4'b0000);
        checkOutput("b2_field", {16'b0, bus.field}, 32'h0020);
        applyStimulus("b3", 4'b0000, 4'b0000);
        checkOutput("b3_field", {16'b0, bus.field}, 32'h0201);
        applyStimulus("b4", 4'b0000, 4'b0000);
        checkOutput("b4_field", {16'b0, bus.field}, 32'h2010);
        checkJudge("b4", 1'b0, 1'b0, 0, 0, 0);

        applyStimulus("b5", 4'b0010, 4'b0000);
        checkJudge("b5", 1'b1, 1'b0, 1, 1, 10);
        applyStimulus("b6", 4'b0000, 4'b0000);
        checkJudge("b6", 1'b0, 1'b0, 1, 1, 10);
        // Same lane pressed twice in one interval counts once.
        applyStimulus("b7", 4'b0001, 4'b0001);
        checkJudge("b7", 1'b1, 1'b0, 2, 2, 20);
        applyStimulus("b8", 4'b0000, 4'b0000);
        applyStimulus("b9", 4'b0000, 4'b0010);
        checkJudge("b9", 1'b1, 1'b0, 3, 3, 30);
        applyStimulus("b10", 4'b0000, 4'b0000);
        // 2-bit combo saturates at 3 while score keeps growing.
        applyStimulus("b11", 4'b1000, 4'b0000);
        checkJudge("b11", 1'b1, 1'b0, 3, 3, 40);
        applyStimulus("b12", 4'b0000, 4'b0000);
        applyStimulus("b13", 4'b0000, 4'b0000);
        checkJudge("b13", 1'b0, 1'b1, 0, 3, 40);
        applyStimulus("b14", 4'b1000, 4'b0000);
        checkJudge("b14", 1'b0, 1'b1, 0, 3, 40);
        checkOutput("b14_field", {16'b0, bus.field}, 32'h2010);

        // Pause at tc=2 with presses on the lane that is about to be judged.
        tick();
        tick();
        bus.game_state = ST_PAUSE;
        bus.btn_lane   = 4'b0010;
        pause_pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.beat_pulse || bus.hit_pulse || bus.miss_pulse) pause_pulses++;
        end
        checkOutput("pause_pulses", pause_pulses, 32'd0);
        checkOutput("pause_field", {16'b0, bus.field}, 32'h2010);
        bus.btn_lane   = 4'b0000;
        bus.game_state = ST_GAME;
        tick();
        checkOutput("resume_no_beat", {31'b0, bus.beat_pulse}, 32'd0);
        tick();
        checkOutput("resume_beat", {31'b0, bus.beat_pulse}, 32'd1);
        checkJudge("b15", 1'b0, 1'b1, 0, 3, 40);
        checkOutput("b15_field", {16'b0, bus.field}, 32'h0104);

        // Async reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_field", {16'b0, bus.field}, 32'h0);
        checkJudge("arst", 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus("r1", 4'b0000, 4'b0000);
        checkOutput("r1_field", {16'b0, bus.field}, 32'h0002);
        applyStimulus("r2", 4'b0000, 4'b0000);
        applyStimulus("r3", 4'b0000, 4'b0000);
        applyStimulus("r4", 4'b0000, 4'b0000);
        applyStimulus("r5", 4'b0010, 4'b0000);
        checkJudge("r5", 1'b1, 1'b0, 1, 1, 10);

        // Synchronous STATE_RESET mid-game.
        bus.game_state = ST_RESET;
        tick();
        tick();
        tick();
        checkOutput("sreset_field", {16'b0, bus.field}, 32'h0);
        checkJudge("sreset", 1'b0, 1'b0, 0, 0, 0);
        checkOutput("sreset_beat", {31'b0, bus.beat_pulse}, 32'd0);
        bus.game_state = ST_GAME;
        applyStimulus("s1", 4'b0000, 4'b0000);
        checkOutput("s1_field", {16'b0, bus.field}, 32'h0002);
        checkJudge("s1", 1'b0, 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
